// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared types and widths for the TDC measurement controller
package tdc_pkg;

    // Width of the delay-line binary position
    localparam int FINE_W = 5;

    // Default coarse counter width
    localparam int COARSE_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } tdc_state_e;

endpackage

// File: rtl/tdc_edge_detect.sv
// rtl/tdc_edge_detect.sv - rising-edge detector on an already synchronised signal
module tdc_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // Track the previous level every cycle so a level held across arming is never an edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/tdc_measure_ctrl.sv
// rtl/tdc_measure_ctrl.sv - arm/hit coarse counter with delay-line fine capture handshake
module tdc_measure_ctrl
    import tdc_pkg::*;
#(
    parameter int COARSE_W  = COARSE_W_DEF,
    parameter int TIMEOUT   = 65535,
    parameter int FINE_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                hit_sync,
    output logic                sample,
    input  logic [FINE_W-1:0]   fine_count,
    input  logic                fine_valid,
    output logic [COARSE_W-1:0] result_coarse,
    output logic [FINE_W-1:0]   result_fine,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                busy,
    output logic                timeout,
    output logic                fine_err
);

    // Wait counter only has to reach FINE_WAIT-1
    localparam int WAIT_W = (FINE_WAIT > 1) ? $clog2(FINE_WAIT) : 1;
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(FINE_WAIT - 1);
    localparam logic [COARSE_W-1:0] TIMEOUT_C = COARSE_W'(TIMEOUT);

    tdc_state_e          state_q;
    logic [COARSE_W-1:0] cnt_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                hit_rise;

    tdc_edge_detect u_edge (
        .clk_i  (clk),
        .rst_i  (rst),
        .sig_i  (hit_sync),
        .rise_o (hit_rise)
    );

    // Measurement sequencer; every output is a register written alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            wait_q        <= '0;
            sample        <= 1'b0;
            timeout       <= 1'b0;
            fine_err      <= 1'b0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            result_coarse <= '0;
            result_fine   <= '0;
        end else begin
            // Strobes default low so each is a single-cycle pulse
            sample   <= 1'b0;
            timeout  <= 1'b0;
            fine_err <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        cnt_q   <= '0;
                        state_q <= ST_ARMED;
                        busy    <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    // A hit on the final counted cycle takes priority over the timeout
                    if (hit_rise) begin
                        result_coarse <= cnt_q;
                        sample        <= 1'b1;
                        wait_q        <= '0;
                        state_q       <= ST_CAPTURE;
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (fine_valid) begin
                        result_fine  <= fine_count;
                        result_valid <= 1'b1;
                        state_q      <= ST_DONE;
                    end else if (wait_q == WAIT_LAST) begin
                        fine_err <= 1'b1;
                        busy     <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// tb/tb_tdc_measure_ctrl.sv - randomized self-checking bench for tdc_measure_ctrl
module tb_tdc_measure_ctrl;
    import tdc_pkg::*;

    localparam int CW = 16;
    localparam int TO = 20;
    localparam int FW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm;
    logic              hit_sync;
    logic              sample;
    logic [FINE_W-1:0] fine_count;
    logic              fine_valid;
    logic [CW-1:0]     result_coarse;
    logic [FINE_W-1:0] result_fine;
    logic              result_valid;
    logic              result_ready;
    logic              busy;
    logic              timeout;
    logic              fine_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tdc_measure_ctrl #(
        .COARSE_W  (CW),
        .TIMEOUT   (TO),
        .FINE_WAIT (FW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .hit_sync      (hit_sync),
        .sample        (sample),
        .fine_count    (fine_count),
        .fine_valid    (fine_valid),
        .result_coarse (result_coarse),
        .result_fine   (result_fine),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .busy          (busy),
        .timeout       (timeout),
        .fine_err      (fine_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " sample"},        32'(sample),        0);
        chk({tag, " timeout"},       32'(timeout),       0);
        chk({tag, " fine_err"},      32'(fine_err),      0);
        chk({tag, " busy"},          32'(busy),          0);
        chk({tag, " result_valid"},  32'(result_valid),  0);
        chk({tag, " result_coarse"}, 32'(result_coarse), 0);
        chk({tag, " result_fine"},   32'(result_fine),   0);
    endtask

    task automatic idle_inputs();
        rst          = 1'b0;
        arm          = 1'b0;
        hit_sync     = 1'b0;
        fine_valid   = 1'b0;
        fine_count   = '0;
        result_ready = 1'b0;
    endtask

    // One measurement, with cycle t=0 the arm cycle. The expected timeline is derived
    // from the measurement parameters: edge at counter c happens in cycle c+1, sample
    // follows one cycle later, fine answer fd cycles after sample, and so on.
    //   c      : coarse count at which the hit edge arrives, -1 for no hit
    //   fd     : cycles from sample to fine_valid (>= FW means it never comes)
    //   rd     : cycles result_valid waits before the consumer accepts
    //   rst_at : cycle at which reset is pulsed, -1 for none
    task automatic run_meas(input int c, input bit pre_high, input int fd,
                            input logic [FINE_W-1:0] fv, input int rd,
                            input bit noise, input int rst_at);
        bit hit, acc, in_wait, rst_fired;
        int t_s, t_f, t_fe, t_to, t_end, rv_lo, rv_hi;
        hit   = (c >= 0);
        acc   = hit && (fd < FW);
        t_s   = hit ? c + 2 : -100;
        t_f   = acc ? c + 2 + fd : -100;
        t_fe  = (hit && !acc) ? c + 2 + FW : -100;
        t_to  = hit ? -100 : TO + 2;
        rv_lo = acc ? t_f + 1 : -100;
        rv_hi = acc ? t_f + 1 + rd : -101;
        t_end = acc ? t_f + 2 + rd : (hit ? t_fe : t_to);
        rst_fired = 1'b0;
        for (int t = -1; t <= t_end; t++) begin
            rst = (t == rst_at);
            arm = (t == 0) || (noise && t >= 1 && t < t_end && $urandom_range(0, 3) == 0);
            if (t < 0 || !hit)   hit_sync = pre_high;
            else if (t < c)      hit_sync = pre_high;
            else if (t == c)     hit_sync = 1'b0;
            else if (t == c + 1) hit_sync = 1'b1;
            else                 hit_sync = noise ? 1'($urandom) : 1'b1;
            if (acc && t == t_f) begin
                fine_valid = 1'b1;
                fine_count = fv;
            end else begin
                in_wait    = hit && t >= t_s && t < (acc ? t_f : t_s + FW);
                fine_count = FINE_W'($urandom);
                fine_valid = in_wait ? 1'b0 : (noise ? 1'($urandom) : 1'b0);
            end
            if (acc && t >= rv_lo && t <= rv_hi) result_ready = (t == rv_hi);
            else result_ready = noise ? 1'($urandom) : 1'b0;

            @(negedge clk);
            chk($sformatf("sample t=%0d", t),   32'(sample),   32'(t == t_s));
            chk($sformatf("timeout t=%0d", t),  32'(timeout),  32'(t == t_to));
            chk($sformatf("fine_err t=%0d", t), 32'(fine_err), 32'(t == t_fe));
            chk($sformatf("busy t=%0d", t),     32'(busy),     32'(t >= 1 && t < t_end));
            chk($sformatf("result_valid t=%0d", t), 32'(result_valid),
                32'(t >= rv_lo && t <= rv_hi));
            if (t >= rv_lo && t <= rv_hi) begin
                chk($sformatf("result_coarse t=%0d", t), 32'(result_coarse), 32'(c));
                chk($sformatf("result_fine t=%0d", t),   32'(result_fine),   32'(fv));
            end
            @(posedge clk);
            #1;
            if (t == rst_at) begin
                rst_fired = 1'b1;
                break;
            end
        end
        idle_inputs();
        if (rst_fired) begin
            @(negedge clk);
            chk_all_zero("after mid-run reset");
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int c, fd, rd, ra;
        bit ph;
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            arm        = 1'($urandom);
            hit_sync   = 1'($urandom);
            fine_valid = 1'($urandom);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;

        // Nominal capture: hit rising at cycle 10 gives coarse 9
        run_meas(9, 1'b0, 1, 5'd17, 3, 1'b0, -1);
        // No hit: timeout when counter reaches TIMEOUT
        run_meas(-1, 1'b0, 1, 5'd0, 0, 1'b0, -1);
        // Level high before arm must not count; fresh edge at counter 5
        run_meas(5, 1'b1, 1, 5'd9, 0, 1'b0, -1);
        // Level held high throughout never counts
        run_meas(-1, 1'b1, 1, 5'd0, 0, 1'b0, -1);
        // Missing fine_valid
        run_meas(7, 1'b0, 99, 5'd3, 0, 1'b0, -1);
        // Reset during CAPTURE, then a fresh measurement
        run_meas(5, 1'b0, 3, 5'd12, 0, 1'b0, 8);
        run_meas(3, 1'b0, 1, 5'd21, 1, 1'b0, -1);
        // Reset during DONE while the consumer stalls, then a fresh measurement
        run_meas(4, 1'b0, 1, 5'd30, 6, 1'b0, 10);
        run_meas(6, 1'b0, 2, 5'd7, 0, 1'b0, -1);
        // Hit on the timeout cycle wins; extra arms and noise ignored
        run_meas(TO, 1'b0, 1, 5'd31, 2, 1'b1, -1);
        // Earliest possible hit and fine answer in the sample cycle
        run_meas(0, 1'b0, 0, 5'd1, 0, 1'b1, -1);
        // Last accepted fine slot
        run_meas(2, 1'b0, FW - 1, 5'd19, 0, 1'b1, -1);

        for (int n = 0; n < 40; n++) begin
            c  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO));
            ph = 1'($urandom);
            fd = int'($urandom_range(0, FW + 1));
            rd = int'($urandom_range(0, 4));
            ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 30)) : -1;
            run_meas(c, ph, fd, FINE_W'($urandom), rd, 1'b1, ra);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
